// File: rtl/cla_pipe_addsub.sv
// Purpose: carry-pipelined carry-lookahead adder/subtractor; one SEG_W-bit segment resolved per stage.
// Latency: NSEG = WIDTH/SEG_W cycles from accepted operands to out_valid, throughput one op per cycle.
// Backpressure: global stall; every stage holds while out_valid=1 and out_ready=0 (in_ready = adv).
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake; a, b, sub, c_in sampled when both are high
//   out_valid / out_ready result handshake; sum (mod 2^WIDTH) and c_out (carry, or borrow when sub=1)
module cla_pipe_addsub #(
    parameter int WIDTH = 96,
    parameter int SEG_W = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int NGRP = SEG_W / GROUP;

    if (GROUP < 1 || SEG_W < GROUP || (SEG_W % GROUP) != 0 ||
        WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_W and SEG_W a multiple of GROUP");
    end

    // Two-level lookahead: per-group P/G, then group carries from the group P/G,
    // then bit carries inside each group seeded by its group carry.
    function automatic logic [SEG_W:0] seg_cla(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             cin
    );
        logic [SEG_W-1:0] p;
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] s;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gg;
        logic [NGRP:0]    gc;
        logic             c;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = 1'b1;
            gg[j] = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
                gp[j] = gp[j] & p[j*GROUP+i];
            end
        end
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        s = '0;
        for (int j = 0; j < NGRP; j++) begin
            c = gc[j];
            for (int i = 0; i < GROUP; i++) begin
                s[j*GROUP+i] = p[j*GROUP+i] ^ c;
                c            = g[j*GROUP+i] | (p[j*GROUP+i] & c);
            end
        end
        return {gc[NGRP], s};
    endfunction

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Inputs seen by stage k. stg_acc holds resolved sum bits below segment k and
    // still-unresolved A bits from segment k upward; stg_b carries B (already inverted for subtract).
    logic             stg_vld [NSEG];
    logic             stg_sub [NSEG];
    logic             stg_cy  [NSEG];
    logic [WIDTH-1:0] stg_acc [NSEG];
    logic [WIDTH-1:0] stg_b   [NSEG];

    // Subtract as a + ~b + !c_in, so the incoming borrow becomes an inverted carry.
    assign stg_vld[0] = in_valid;
    assign stg_sub[0] = sub;
    assign stg_cy[0]  = c_in ^ sub;
    assign stg_acc[0] = a;
    assign stg_b[0]   = sub ? ~b : b;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG_W:0]   seg_res;
        logic [WIDTH-1:0] acc_d;
        logic             vld_q;
        logic             sub_q;
        logic             cy_q;
        logic [WIDTH-1:0] acc_q;

        always_comb begin
            seg_res = seg_cla(stg_acc[k][k*SEG_W +: SEG_W], stg_b[k][k*SEG_W +: SEG_W], stg_cy[k]);
            acc_d   = stg_acc[k];
            acc_d[k*SEG_W +: SEG_W] = seg_res[SEG_W-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                sub_q <= 1'b0;
                cy_q  <= 1'b0;
                acc_q <= '0;
            end else if (adv) begin
                vld_q <= stg_vld[k];
                sub_q <= stg_sub[k];
                cy_q  <= seg_res[SEG_W];
                acc_q <= acc_d;
            end
        end

        if (k < NSEG-1) begin : g_fwd
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv) begin
                    b_q <= stg_b[k];
                end
            end

            assign stg_vld[k+1] = vld_q;
            assign stg_sub[k+1] = sub_q;
            assign stg_cy[k+1]  = cy_q;
            assign stg_acc[k+1] = acc_q;
            assign stg_b[k+1]   = b_q;
        end else begin : g_out
            assign out_valid = vld_q;
            assign sum       = acc_q;
            // Final carry of a + ~b + !c_in is the inverse of the borrow.
            assign c_out     = cy_q ^ sub_q;
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Purpose: scoreboard bench for cla_pipe_addsub at 96/32/4 (latency 3) and 64/16/4 (latency 4).
// Latency: drivers push expected results at acceptance; monitors pop on each output transfer.
// Backpressure: out_ready of the 96-bit instance is randomly dropped about 40% of cycles in one phase.
module tb_cla_pipe_addsub;

    localparam int W  = 96;
    localparam int W2 = 64;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          iv, ir, ov, ordy, sb, ci, co;
    logic [W-1:0]  a, b, s;
    logic          iv2, ir2, ov2, ordy2, sb2, ci2, co2;
    logic [W2-1:0] a2, b2, s2;
    logic          bp_en = 1'b0;

    exp_t q96[$];
    exp_t q64[$];
    int   checks   = 0;
    int   failures = 0;

    cla_pipe_addsub #(.WIDTH(96), .SEG_W(32), .GROUP(4)) u_dut96 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .sub(sb), .c_in(ci), .out_valid(ov), .out_ready(ordy), .sum(s), .c_out(co)
    );

    cla_pipe_addsub #(.WIDTH(64), .SEG_W(16), .GROUP(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .sub(sb2), .c_in(ci2), .out_valid(ov2), .out_ready(ordy2), .sum(s2), .c_out(co2)
    );

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] sv, input logic cv);
        exp_t e;
        e.s = sv;
        e.c = cv;
        return e;
    endfunction

    // Reference: plain integer add/subtract one bit wider; bit W is carry or borrow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sbv, input logic cv);
        logic [W+1:0] r;
        if (sbv) r = {2'b00, x} - {2'b00, y} - {{(W+1){1'b0}}, cv};
        else     r = {2'b00, x} + {2'b00, y} + {{(W+1){1'b0}}, cv};
        return mk(r[W-1:0], r[W]);
    endfunction

    initial begin
        ordy = 1'b1;
        forever begin
            @(negedge clk);
            ordy = bp_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
        end
    end

    initial begin : mon96
        exp_t held;
        exp_t e;
        logic held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid96", (W+1)'(ov), (W+1)'(1));
                    chk("hold_data96", {s, co}, held);
                end
                chk("in_ready96", (W+1)'(ir), (W+1)'(!ov | ordy));
                if (ov && ordy) begin
                    if (q96.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious96: got %h expected no output", {s, co});
                    end else begin
                        e = q96.pop_front();
                        chk("result96", {s, co}, e);
                    end
                end
                held_v = ov && !ordy;
                held   = {s, co};
            end
        end
    end

    initial begin : mon64
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ov2 && ordy2) begin
                if (q64.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious64: got %h expected no output", {s2, co2});
                end else begin
                    e = q64.pop_front();
                    chk("result64", {{(W-W2){1'b0}}, s2, co2}, e);
                end
            end
        end
    end

    task automatic send96(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sbv, input logic cv, input exp_t e);
        int n = 0;
        @(negedge clk);
        a = x; b = y; sb = sbv; ci = cv; iv = 1'b1;
        #1;
        while (!ir && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ir) begin
            failures++;
            $display("FAIL send96_timeout: in_ready got 0 expected 1");
        end else begin
            q96.push_back(e);
        end
    endtask

    task automatic send64(input logic [W2-1:0] x, input logic [W2-1:0] y,
                          input logic sbv, input logic cv, input exp_t e);
        int n = 0;
        @(negedge clk);
        a2 = x; b2 = y; sb2 = sbv; ci2 = cv; iv2 = 1'b1;
        #1;
        while (!ir2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ir2) begin
            failures++;
            $display("FAIL send64_timeout: in_ready got 0 expected 1");
        end else begin
            q64.push_back(e);
        end
    endtask

    // Count negedges after acceptance until out_valid shows up.
    task automatic lat96(output int lat);
        @(negedge clk);
        iv = 1'b0;
        #1;
        lat = 1;
        while (!ov && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic lat64(output int lat);
        @(negedge clk);
        iv2 = 1'b0;
        #1;
        lat = 1;
        while (!ov2 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q96.size() != 0 || q64.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q96.size() != 0 || q64.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q96.size(), q64.size());
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] x, y;
        logic sbv, cv;

        rst_n = 1'b0;
        iv = 1'b1; a = '1; b = '1; sb = 1'b0; ci = 1'b1;
        iv2 = 1'b1; a2 = '1; b2 = '1; sb2 = 1'b0; ci2 = 1'b1; ordy2 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_out_valid96", (W+1)'(ov), (W+1)'(0));
        end
        rst_n = 1'b1;
        iv = 1'b0;
        iv2 = 1'b0;
        #1;
        chk("reset_out_valid96_rel", (W+1)'(ov), (W+1)'(0));
        chk("reset_sum96", {s, co}, '0);
        chk("reset_in_ready96", (W+1)'(ir), (W+1)'(1));
        chk("reset_out_valid64", (W+1)'(ov2), (W+1)'(0));
        chk("reset_sum64", (W+1)'({s2, co2}), '0);
        chk("reset_in_ready64", (W+1)'(ir2), (W+1)'(1));

        // Directed vectors, expected values computed by hand.
        send96({W{1'b1}}, 96'd1, 1'b0, 1'b0, mk('0, 1'b1));
        lat96(lat);
        chk("latency96", (W+1)'(lat), (W+1)'(3));
        send96(96'd5, 96'd7, 1'b1, 1'b0, mk(96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1));
        send96(96'd7, 96'd5, 1'b1, 1'b1, mk(96'd1, 1'b0));
        send96({W{1'b1}}, {W{1'b1}}, 1'b0, 1'b1, mk({W{1'b1}}, 1'b1));
        send96(96'd0, 96'd0, 1'b1, 1'b1, mk({W{1'b1}}, 1'b1));
        send96(96'h0000_0000_FFFF_FFFF_FFFF_FFFF, 96'd0, 1'b0, 1'b1,
               mk(96'h0000_0001_0000_0000_0000_0000, 1'b0));
        send96(96'h8000_0000_0000_0000_0000_0000, 96'h8000_0000_0000_0000_0000_0000, 1'b0, 1'b0,
               mk(96'd0, 1'b1));
        send96(96'd0, 96'd0, 1'b1, 1'b0, mk(96'd0, 1'b0));
        send96(96'h0000_0001_0000_0000_0000_0000, 96'd1, 1'b1, 1'b0,
               mk(96'h0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b0));
        @(negedge clk);
        iv = 1'b0;
        drain();

        // Back-to-back streaming with out_ready held high.
        for (int i = 0; i < 100; i++) begin
            x = {$urandom, $urandom, $urandom};
            y = {$urandom, $urandom, $urandom};
            sbv = 1'($urandom_range(0, 1));
            cv  = 1'($urandom_range(0, 1));
            send96(x, y, sbv, cv, model(x, y, sbv, cv));
        end
        @(negedge clk);
        iv = 1'b0;
        drain();

        // Streaming under random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            x = {$urandom, $urandom, $urandom};
            y = (i % 4 == 0) ? ~x : {$urandom, $urandom, $urandom};
            sbv = 1'($urandom_range(0, 1));
            cv  = 1'($urandom_range(0, 1));
            send96(x, y, sbv, cv, model(x, y, sbv, cv));
        end
        @(negedge clk);
        iv = 1'b0;
        bp_en = 1'b0;
        drain();

        // Reset with three operations in flight.
        send96(96'd10, 96'd20, 1'b0, 1'b0, mk(96'd30, 1'b0));
        send96(96'd11, 96'd21, 1'b0, 1'b0, mk(96'd32, 1'b0));
        send96(96'd12, 96'd22, 1'b0, 1'b0, mk(96'd34, 1'b0));
        @(posedge clk);
        #2;
        chk("inflight_valid96", (W+1)'(ov), (W+1)'(1));
        rst_n = 1'b0;
        iv = 1'b0;
        q96.delete();
        #1;
        chk("async_drop96", (W+1)'(ov), (W+1)'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send96(96'd7, 96'd5, 1'b1, 1'b1, mk(96'd1, 1'b0));
        @(negedge clk);
        iv = 1'b0;
        drain();

        // 64-bit, 16-bit segment instance: latency 4.
        send64({W2{1'b1}}, 64'd1, 1'b0, 1'b0, mk('0, 1'b1));
        lat64(lat);
        chk("latency64", (W+1)'(lat), (W+1)'(4));
        send64(64'd5, 64'd7, 1'b1, 1'b0, mk(96'h0000_0000_FFFF_FFFF_FFFF_FFFE, 1'b1));
        send64(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(96'h0000_0000_0000_0001_0000_0000, 1'b0));
        send64(64'h0001_0000_0000_0000, 64'd1, 1'b1, 1'b0, mk(96'h0000_0000_0000_FFFF_FFFF_FFFF, 1'b0));
        @(negedge clk);
        iv2 = 1'b0;
        drain();

        for (int i = 0; i < 4; i++) begin
            send64(64'(i + 100), 64'd1, 1'b0, 1'b0, mk(96'(i + 101), 1'b0));
        end
        @(posedge clk);
        #2;
        chk("inflight_valid64", (W+1)'(ov2), (W+1)'(1));
        rst_n = 1'b0;
        iv2 = 1'b0;
        q64.delete();
        #1;
        chk("async_drop64", (W+1)'(ov2), (W+1)'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send64(64'd7, 64'd5, 1'b1, 1'b1, mk(96'd1, 1'b0));
        @(negedge clk);
        iv2 = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, carry-pipelined carry-lookahead adder/subtractor for the wide butterfly datapath (default 96 bits).
- The operand is split into NSEG = WIDTH/SEG_W segments, one segment resolved per pipeline stage.
- Each segment uses 4-bit group lookahead (group P/G, then a second lookahead level across groups); the segment carry is registered into the next stage.
- Adds subtract mode, chained carry/borrow in and out, and a valid/ready handshake with global stall.

Parameters:
- WIDTH, 96, operand and result width; must be a multiple of SEG_W.
- SEG_W, 32, bits resolved per pipeline stage; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group.
- Derived: NSEG = WIDTH/SEG_W (default 3) = latency in cycles. Illegal combinations stop elaboration.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand handshake valid.
- in_ready  out  1  operand handshake ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B+c_in; 1 = A-B-c_in.
- c_in  in  1  carry in (add) or borrow in (sub).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- sum  out  WIDTH  result modulo 2^WIDTH.
- c_out  out  1  carry out (add) or borrow out (sub).

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, out_valid, sum, c_out and internal skew/carry registers clear to 0. in_ready is combinational, so it is 1 while the pipe is empty. Reset mid-operation discards in-flight data, with no partial results after release.
- Advance: adv = !out_valid | out_ready; in_ready = adv. All stages shift together on adv; nothing moves when adv=0 (global stall). Operands are captured only when in_valid & in_ready.
- Operand prep at capture:
  - b_eff = sub ? ~b : b.
  - carry0 = c_in ^ sub, so sub=1 gives a + ~b + !c_in = a - b - c_in.
- Stage k (k=0..NSEG-1):
  - adds segment k of a and b_eff with the carry registered from stage k-1 (carry0 for k=0), using GROUP-bit lookahead;
  - registers segment-k sum bits and the segment carry;
  - passes lower, already-resolved sum segments and upper, unresolved operand segments through skew registers;
  - carries the sub flag along with the data.
- Output:
  - sum is the full concatenated result.
  - c_out = final carry ^ sub, i.e. carry in add mode, borrow in sub mode.
- Latency: exactly NSEG cycles from accepted input to out_valid when never stalled. Throughput is 1 per cycle.
- Bubbles (valid=0 slots) propagate without corrupting neighbours. While out_valid=0, the contents of sum/c_out are don't-care, but they are held stable when stalled with out_valid=1.
- Simultaneous accept and output: allowed in the same cycle when out_ready=1.
- Wrap-around: the result is truncated to WIDTH bits; overflow is visible only via c_out.
- Full carry-chain propagation across all segments (e.g. all-ones + 1) must be correct. The stage-to-stage carry is the only inter-segment path.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, sum=0, c_out=0, in_ready=1 after release; no spurious output.
- Full-chain carry: a=96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, sub=0, c_in=0 -> after 3 cycles sum=0, c_out=1.
- Subtract with borrow:
  - a=5, b=7, sub=1, c_in=0 -> sum=2^96-2, c_out=1.
  - a=7, b=5, sub=1, c_in=1 -> sum=1, c_out=0.
- Streaming: 100 back-to-back random add/sub ops, out_ready=1 -> one result per cycle in order, latency 3, matches reference model including c_out.
- Backpressure: random out_ready toggling (about 40% low) during streaming -> no loss or duplication; sum/c_out stable while out_valid=1 and out_ready=0; in_ready tracks adv.
- Mid-operation reset: assert rst_n=0 with 3 ops in flight -> out_valid drops asynchronously; first result after release corresponds only to post-reset inputs. Repeat with WIDTH=64, SEG_W=16, GROUP=4 (latency 4).
